// File: rtl/mul8_seq_if.sv
// Handshake and data bundle for mul8_seq: operands and start in, ready/done/product out.
interface mul8_seq_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        signed_mode;
  logic        ready;
  logic        done;
  logic [15:0] product;

  modport master (
    output start, a, b, signed_mode,
    input  ready, done, product
  );

  modport slave (
    input  start, a, b, signed_mode,
    output ready, done, product
  );
endinterface

// File: rtl/mul8_seq.sv
// Sequential 8x8 shift-and-add multiplier (unsigned or two's complement).
// Operates on magnitudes and applies the sign once, after eight add/shift iterations.
module mul8_seq (
  input  logic       clk,
  input  logic       rst_n,
  mul8_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [7:0]  acc_hi_q, acc_hi_d;
  logic [7:0]  mult_q, mult_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [2:0]  count_q, count_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;
  logic [15:0] product_q, product_d;
  logic [8:0]  sum;

  function automatic logic [8:0] add8(input logic [7:0] x, input logic [7:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [7:0] neg8(input logic [7:0] x);
    return ~x + 8'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    mult_d    = mult_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    sign_d    = sign_q;
    product_d = product_q;
    done_d    = 1'b0;
    sum       = {1'b0, acc_hi_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // neg8(0x80) reads back as 128 unsigned, so -128 needs no special case
          mcand_d  = (bus.signed_mode && bus.a[7]) ? neg8(bus.a) : bus.a;
          mult_d   = (bus.signed_mode && bus.b[7]) ? neg8(bus.b) : bus.b;
          sign_d   = bus.signed_mode & (bus.a[7] ^ bus.b[7]);
          acc_hi_d = 8'h00;
          count_d  = 3'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mult_q[0]) begin
          sum = add8(acc_hi_q, mcand_q);
        end
        // Shift {carry, acc_hi, mult} right; the low byte collects product bits
        acc_hi_d = sum[8:1];
        mult_d   = {sum[0], mult_q[7:1]};
        count_d  = count_q + 3'd1;
        if (count_q == 3'd7) begin
          state_d = FIX;
        end
      end
      FIX: begin
        product_d = sign_q ? (~{acc_hi_q, mult_q} + 16'd1) : {acc_hi_q, mult_q};
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_hi_q  <= 8'h00;
      mult_q    <= 8'h00;
      mcand_q   <= 8'h00;
      count_q   <= 3'd0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      mult_q    <= mult_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: directed and random operations against an
// arithmetic reference, plus busy, back-to-back and asynchronous-reset scenarios.
module tb_mul8_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mul8_seq_if bus ();

  mul8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer multiply, truncated to the 16-bit product
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic sm);
    int sx;
    int sy;
    int r;
    logic [31:0] rv;
    sx = {{24{sm & x[7]}}, x};
    sy = {{24{sm & y[7]}}, y};
    r  = sx * sy;
    rv = r;
    return rv[15:0];
  endfunction

  // Issue one operation from IDLE and wait for its done; lat counts negedges after the accept edge
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic sm,
                       output logic [15:0] prod, output int lat, output bit ready_low_ok);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.a           = ia;
    bus.b           = ib;
    bus.signed_mode = sm;
    @(negedge clk);
    bus.start    = 1'b0;
    lat          = 0;
    prod         = 16'hxxxx;
    ready_low_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 3) begin
        bus.a           = 8'($urandom);
        bus.b           = 8'($urandom);
        bus.signed_mode = 1'($urandom);
      end
      if (bus.done) begin
        lat  = k;
        prod = bus.product;
        break;
      end
      if (bus.ready) ready_low_ok = 1'b0;
    end
    $display("op a=%02h b=%02h sm=%0d product=%04h latency=%0d", ia, ib, sm, prod, lat);
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.a           = 8'h00;
    bus.b           = 8'h00;
    bus.signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", bus.ready);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.product !== 16'h0000) begin
      failures++;
      $display("FAIL reset_product: got %04h expected 0000", bus.product);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [7:0]  va [4] = '{8'd13, 8'hFF, 8'hFD, 8'h00};
    logic [7:0]  vb [4] = '{8'd11, 8'hFF, 8'h05, 8'hA7};
    logic [15:0] ve [4] = '{16'h008F, 16'hFE01, 16'h04F1, 16'h0000};
    logic [15:0] got;
    int          lat;
    bit          rok;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 1'b0, got, lat, rok);
      checks++;
      if (got !== ve[i]) begin
        failures++;
        $display("FAIL unsigned_product[%0d]: got %04h expected %04h", i, got, ve[i]);
      end
      checks++;
      if (lat != 10) begin
        failures++;
        $display("FAIL unsigned_latency[%0d]: got %0d expected 10", i, lat);
      end
      checks++;
      if (!rok || bus.ready !== 1'b1) begin
        failures++;
        $display("FAIL unsigned_ready[%0d]: low_ok=%0d ready_at_done=%b expected 1/1", i, rok, bus.ready);
      end
    end
    for (int i = 0; i < 25; i++) begin
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [15:0] exp_p;
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      exp_p = ref_mul(ra, rb, 1'b0);
      do_op(ra, rb, 1'b0, got, lat, rok);
      checks++;
      if (got !== exp_p || lat != 10) begin
        failures++;
        $display("FAIL unsigned_random: a=%02h b=%02h got %04h lat %0d expected %04h lat 10", ra, rb, got, lat, exp_p);
      end
    end
  endtask

  task automatic test_signed();
    logic [7:0]  va [4] = '{8'hFD, 8'h80, 8'h80, 8'h00};
    logic [7:0]  vb [4] = '{8'h05, 8'h80, 8'h7F, 8'h80};
    logic [15:0] ve [4] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0000};
    logic [15:0] got;
    int          lat;
    bit          rok;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 1'b1, got, lat, rok);
      checks++;
      if (got !== ve[i] || lat != 10) begin
        failures++;
        $display("FAIL signed_product[%0d]: got %04h lat %0d expected %04h lat 10", i, got, lat, ve[i]);
      end
    end
    for (int i = 0; i < 30; i++) begin
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic        sm;
      logic [15:0] exp_p;
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      sm    = 1'($urandom);
      exp_p = ref_mul(ra, rb, sm);
      do_op(ra, rb, sm, got, lat, rok);
      checks++;
      if (got !== exp_p || lat != 10) begin
        failures++;
        $display("FAIL signed_random: a=%02h b=%02h sm=%0d got %04h lat %0d expected %04h lat 10", ra, rb, sm, got, lat, exp_p);
      end
    end
  endtask

  task automatic test_busy();
    int          ndone;
    int          first_k;
    logic [15:0] got;
    ndone   = 0;
    first_k = 0;
    got     = 16'hxxxx;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.a           = 8'd2;
    bus.b           = 8'd3;
    bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 4) begin
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd9;
      end
      if (k == 5) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          first_k = k;
          got     = bus.product;
        end
      end
    end
    $display("busy: dones=%0d first_at=%0d product=%04h", ndone, first_k, got);
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL busy_done_count: got %0d expected 1", ndone);
    end
    checks++;
    if (got !== 16'h0006 || first_k != 10) begin
      failures++;
      $display("FAIL busy_product: got %04h at %0d expected 0006 at 10", got, first_k);
    end
  endtask

  task automatic test_back_to_back();
    int k1;
    int k2;
    bit hold_ok;
    k1      = 0;
    k2      = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.a           = 8'd7;
    bus.b           = 8'd6;
    bus.signed_mode = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        k1 = k;
        break;
      end
    end
    $display("b2b first: product=%04h at %0d", bus.product, k1);
    checks++;
    if (bus.product !== 16'h002A || k1 != 10) begin
      failures++;
      $display("FAIL b2b_first: got %04h at %0d expected 002A at 10", bus.product, k1);
    end
    // start stays high: the request is taken on the edge that ends the done cycle
    bus.a = 8'h5A;
    bus.b = 8'h0A;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done) begin
        k2 = k;
        break;
      end
      if (bus.product !== 16'h002A) hold_ok = 1'b0;
    end
    $display("b2b second: product=%04h at %0d", bus.product, k2);
    checks++;
    if (!hold_ok) begin
      failures++;
      $display("FAIL b2b_hold: got product change before second done expected 002A held");
    end
    checks++;
    if (bus.product !== 16'h0384 || k2 != 10) begin
      failures++;
      $display("FAIL b2b_second: got %04h at %0d expected 0384 at 10", bus.product, k2);
    end
  endtask

  task automatic test_reset_mid_op();
    int          ndone;
    bit          prod_zero;
    logic [15:0] got;
    int          lat;
    bit          rok;
    ndone     = 0;
    prod_zero = 1'b1;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.a           = 8'd200;
    bus.b           = 8'd100;
    bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("reset mid-op: ready=%b done=%b product=%04h", bus.ready, bus.done, bus.product);
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.product !== 16'h0000) begin
      failures++;
      $display("FAIL abort_immediate: got ready=%b done=%b product=%04h expected 1 0 0000",
               bus.ready, bus.done, bus.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.product !== 16'h0000) prod_zero = 1'b0;
    end
    checks++;
    if (ndone != 0 || !prod_zero) begin
      failures++;
      $display("FAIL abort_no_done: got dones=%0d product_zero=%0d expected 0 1", ndone, prod_zero);
    end
    do_op(8'd77, 8'd3, 1'b0, got, lat, rok);
    checks++;
    if (got !== 16'h00E7 || lat != 10) begin
      failures++;
      $display("FAIL after_reset_op: got %04h lat %0d expected 00E7 lat 10", got, lat);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
